// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: state encoding and direction constants shared by counter_ctrl and counter_core
package counter_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP = 1'b1;
endpackage

// File: rtl/counter_core.sv
// counter_core: synchronous loadable up/down counter with a terminal-count flag
module counter_core
  import counter_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic         dir,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         at_terminal
);
  logic [N-1:0] q_d, q_q;
  always_comb q_d = load ? d : !en ? q_q : (dir == DIR_UP) ? q_q + N'(1) : q_q - N'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
  assign at_terminal = (dir == DIR_UP) ? &q_q : ~|q_q;
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop/pause sequencer around counter_core with terminal-count, done and auto-reload.
// Optional prescaler enabled by defining COUNTER_CTRL_PRESCALE_EN.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef COUNTER_CTRL_PRESCALE_EN
  input  logic [3:0]   prescale,
`endif
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] load_val,
  input  logic         dir,
  input  logic         auto_reload,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         tc,
  output logic         done
);
  state_e       state_q;
  logic         dir_q, done_q, tick, at_term, start_ok, run_go, term_hit;
  logic [N-1:0] preset_q;
  assign start_ok = state_q == IDLE && start && !stop;
  assign run_go   = state_q == RUN && !stop && tick;
  assign term_hit = run_go && at_term;
  counter_core #(.N(N)) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (run_go && !at_term),
    .load        (start_ok || (term_hit && auto_reload)),
    .dir         (dir_q),
    .d           (start_ok ? load_val : preset_q),
    .q           (q),
    .at_terminal (at_term)
  );
`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [3:0] presc_q, pre_q;
  assign tick = pre_q == presc_q;
  // outside an uninterrupted RUN the divider sits at zero, so start/resume/pause all clear it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      presc_q <= '0;
      pre_q   <= '0;
    end else begin
      if (start_ok) presc_q <= prescale;
      pre_q <= (state_q == RUN && !stop && !tick) ? pre_q + 4'd1 : 4'd0;
    end
`else
  assign tick = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      dir_q    <= DIR_DOWN;
      preset_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= term_hit;
      case (state_q)
        IDLE: if (start_ok) begin
          state_q  <= RUN;
          dir_q    <= dir;
          preset_q <= load_val;
        end
        RUN: if (stop) state_q <= PAUSE;
             else if (term_hit && !auto_reload) state_q <= IDLE;
        PAUSE: if (stop) state_q <= IDLE;
               else if (start) state_q <= RUN;
        default: state_q <= IDLE;
      endcase
    end
  assign busy = state_q != IDLE;
  assign tc   = state_q == RUN && at_term && tick;
  assign done = done_q;
endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Sequencer for an N-bit loadable up/down counter.
- Takes start/stop commands and a preset, runs the count in the selected direction, and flags the terminal count.
- Signals completion, and optionally auto-reloads.
- Sits between software/FSM control logic and the counter datapath; replaces ad-hoc ripple counters where synchronous, controllable timing is needed.

Parameters:
- N, 4, counter width in bits (N >= 2).

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: level, sampled each cycle; begins a run (IDLE) or resumes (PAUSE).
- stop, input, 1: level, sampled each cycle; pauses (RUN) or aborts (PAUSE).
- load_val, input, N: preset; sampled only when start is accepted in IDLE.
- dir, input, 1: 1 = up, 0 = down; sampled only when start is accepted in IDLE.
- auto_reload, input, 1: sampled at terminal count; 1 = reload and continue.
- q, output, N: current count.
- busy, output, 1: high in RUN or PAUSE.
- tc, output, 1: combinational; high while state==RUN and q==terminal.
- done, output, 1: registered one-cycle pulse after each terminal count.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, q=0, latched dir=0, latched preset=0, done=0; busy=0 and tc=0.
- Terminal value: 0 when counting down; 2^N-1 when counting up.
- IDLE:
  - q holds its value.
  - start=1 and stop=0 at an edge: q<=load_val; dir and load_val are latched; state<=RUN.
  - start with stop=1 is ignored.
- RUN:
  - Each edge with q!=terminal: q<=q-1 (down) or q+1 (up).
  - q==terminal (tc=1) with auto_reload=1: q<=latched preset, done<=1, state stays RUN.
  - q==terminal (tc=1) with auto_reload=0: state<=IDLE, done<=1, q holds the terminal value.
  - stop=1 overrides counting and terminal handling: state<=PAUSE, q holds, no done.
  - start in RUN is ignored.
- PAUSE:
  - q holds; tc=0.
  - stop=1 → IDLE, abort, no done. Stop wins over simultaneous start.
  - start=1 (stop=0) → RUN; counting continues from the held q.
- Latency:
  - A start accepted at edge k gives q=load_val after edge k.
  - A run without stops lasts |terminal - load_val| + 1 RUN cycles.
  - done is high exactly the one cycle after the tc cycle.
- Boundaries:
  - load_val == terminal: tc is high in the first RUN cycle.
  - The arithmetic never wraps, because the terminal check always precedes the increment/decrement.
- Reset mid-run: immediate return to the reset state; no done pulse.

Optional Feature:
- Macro COUNTER_CTRL_PRESCALE_EN.
- Defined:
  - Adds input prescale[3:0], sampled at start.
  - The count/terminal action occurs only on every (prescale+1)-th RUN cycle, on the internal tick.
  - The prescaler is cleared on start, on entering PAUSE and on reset.
  - tc is additionally qualified with the tick.
- Undefined: no prescale port; tick is constantly 1; behaviour exactly as above.

Decomposition:
- Package counter_ctrl_pkg:
  - state enum typedef (IDLE, RUN, PAUSE);
  - constants DIR_DOWN=1'b0 and DIR_UP=1'b1.
- Sub-module counter_core (same clk/rst_n):
  - synchronous loadable up/down counter;
  - inputs en, load, dir, d; output q; plus an at_terminal flag.
- counter_ctrl keeps the FSM, the latches, done generation and the prescaler.

Test Plan:
- N=4, load_val=3, dir=0, start pulse → q: 3,2,1,0 (tc=1 at 0); done=1 the next cycle; busy=0; q stays 0.
- load_val=13, dir=1, auto_reload=1 → q: 13,14,15 (tc), 13,14,15…; done pulses every 3 cycles; busy stays 1.
- Down from 9: stop while q=6 → q holds 6 in PAUSE; start → 5,4,…0; done once; the pause length is not counted.
- From PAUSE, start=1 and stop=1 together → IDLE, no done, q holds its value.
- Drop rst_n for half a cycle while q=7 in RUN → q=0, busy=0, done=0 immediately; a subsequent start works normally.
- With COUNTER_CTRL_PRESCALE_EN, prescale=2, load_val=2, down → q changes every 3 cycles; done 1 cycle after the tick at q=0.
